// File: rtl/pc_fetch_sequencer.sv
`timescale 1ns/1ps
// Program counter owner: steps each instruction through
// fetch, BRAM wait, execute and a one-cycle commit.
module pc_fetch_sequencer #(
  parameter int          IMEM_AW     = 10,
  parameter int          IMEM_LAT    = 1,
  parameter int          EXEC_CYCLES = 2,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               halt,
  input  logic [31:0]        final_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               imem_en,
  input  logic [31:0]        imem_dout,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               commit,
  output logic               halted,
  output logic               misalign,
  output logic [31:0]        retired
);

  localparam int LAT_LAST  = (IMEM_LAT > 1) ? IMEM_LAT - 2 : 0;
  localparam int EXEC_LAST = EXEC_CYCLES - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_MEM_WAIT,
    S_EXEC,
    S_COMMIT,
    S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [1:0]  lat_q, lat_d;
  logic [2:0]  exec_q, exec_d;
  logic [31:0] ret_q, ret_d;
  logic        mis_q, mis_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      lat_q   <= '0;
      exec_q  <= '0;
      ret_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      lat_q   <= lat_d;
      exec_q  <= exec_d;
      ret_q   <= ret_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    lat_d       = lat_q;
    exec_d      = exec_q;
    ret_d       = ret_q;
    mis_d       = mis_q;
    imem_en     = 1'b0;
    instr_valid = 1'b0;
    commit      = 1'b0;
    halted      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_en = 1'b1;
        lat_d   = '0;
        exec_d  = '0;
        if (IMEM_LAT == 1) begin
          state_d = S_EXEC;
          instr_d = imem_dout;
        end else begin
          state_d = S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: begin
        imem_en = 1'b1;
        lat_d   = lat_q + 2'd1;
        if (lat_q == LAT_LAST[1:0]) begin
          state_d = S_EXEC;
          instr_d = imem_dout;
        end
      end
      S_EXEC: begin
        instr_valid = 1'b1;
        exec_d      = exec_q + 3'd1;
        // halt is only honoured before any execute cycle has elapsed
        if (halt && exec_q == 3'd0) begin
          state_d = S_HALT;
        end else if (exec_q == EXEC_LAST[2:0]) begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        instr_valid = 1'b1;
        commit      = 1'b1;
        pc_d        = {final_pc[31:2], 2'b00};
        mis_d       = mis_q | (|final_pc[1:0]);
        ret_d       = ret_q + 32'd1;
        state_d     = run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign imem_addr = pc_q[IMEM_AW+1:2];
  assign pc        = pc_q;
  assign pc_plus4  = pc_q + 32'd4;
  assign instr     = instr_q;
  assign misalign  = mis_q;
  assign retired   = ret_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
`timescale 1ns/1ps
// Bench for pc_fetch_sequencer: two parameterisations checked
// against an instruction-level model plus literal expectations.
module tb_pc_fetch_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  function automatic logic [31:0] memw(input logic [9:0] a);
    return 32'hA5A5_0001 + {22'b0, a};
  endfunction

  // DUT A: IMEM_LAT=1, EXEC_CYCLES=2
  logic        run_a, halt_a, fp_ovr;
  logic [31:0] fp_val, final_pc_a, dout_a;
  logic [9:0]  addr_a;
  logic        en_a, iv_a, commit_a, halted_a, mis_a;
  logic [31:0] instr_a, pc_a, pp4_a, ret_a;

  assign final_pc_a = fp_ovr ? fp_val : pp4_a;
  assign dout_a     = en_a ? memw(addr_a) : 32'hDEAD_BEEF;

  pc_fetch_sequencer #(
    .IMEM_AW(10), .IMEM_LAT(1), .EXEC_CYCLES(2),
    .RESET_PC(32'h0)
  ) u_a (
    .clk(clk), .rst(rst), .run(run_a), .halt(halt_a),
    .final_pc(final_pc_a), .imem_addr(addr_a),
    .imem_en(en_a), .imem_dout(dout_a), .instr(instr_a),
    .instr_valid(iv_a), .pc(pc_a), .pc_plus4(pp4_a),
    .commit(commit_a), .halted(halted_a),
    .misalign(mis_a), .retired(ret_a)
  );

  // DUT B: IMEM_LAT=3, EXEC_CYCLES=1
  logic        run_b;
  logic        halt_b = 1'b0;
  logic [31:0] dout_b;
  logic [9:0]  addr_b;
  logic        en_b, iv_b, commit_b, halted_b, mis_b;
  logic [31:0] instr_b, pc_b, pp4_b, ret_b;
  logic        en_b1 = 1'b0, en_b2 = 1'b0;
  logic [9:0]  ab1 = '0, ab2 = '0;

  // data appears only after the address was held enabled for 3 cycles
  always @(posedge clk) begin
    en_b1 <= en_b;
    ab1   <= addr_b;
    en_b2 <= en_b1;
    ab2   <= ab1;
  end
  assign dout_b = (en_b1 && en_b2) ? memw(ab2) : 32'hDEAD_BEEF;

  pc_fetch_sequencer #(
    .IMEM_AW(10), .IMEM_LAT(3), .EXEC_CYCLES(1),
    .RESET_PC(32'h0)
  ) u_b (
    .clk(clk), .rst(rst), .run(run_b), .halt(halt_b),
    .final_pc(pp4_b), .imem_addr(addr_b),
    .imem_en(en_b), .imem_dout(dout_b), .instr(instr_b),
    .instr_valid(iv_b), .pc(pc_b), .pc_plus4(pp4_b),
    .commit(commit_b), .halted(halted_b),
    .misalign(mis_b), .retired(ret_b)
  );

  // instruction-level model: mode 0 idle, 1 busy, 2 halted;
  // k is the cycle index within the current instruction
  typedef struct {
    int          mode;
    int          k;
    logic [31:0] pc;
    logic [31:0] ret;
    logic [31:0] ins;
    logic        mis;
  } ms_t;

  function automatic ms_t ms_rst();
    ms_t r;
    r.mode = 0; r.k = 0; r.pc = 32'h0;
    r.ret = 32'h0; r.ins = 32'h0; r.mis = 1'b0;
    return r;
  endfunction

  function automatic ms_t step(input ms_t s, input int lat,
                               input int ec, input logic run,
                               input logic hlt,
                               input logic [31:0] fp);
    ms_t n;
    n = s;
    if (s.mode == 0) begin
      if (run) begin n.mode = 1; n.k = 0; end
    end else if (s.mode == 1) begin
      if (s.k == lat && hlt) begin
        n.mode = 2;
      end else if (s.k == lat + ec) begin
        n.pc   = {fp[31:2], 2'b00};
        n.mis  = s.mis | (fp[1:0] != 2'b00);
        n.ret  = s.ret + 32'd1;
        n.mode = run ? 1 : 0;
        n.k    = 0;
      end else begin
        if (s.k == lat - 1) n.ins = memw(s.pc[11:2]);
        n.k = s.k + 1;
      end
    end
    return n;
  endfunction

  ms_t ma, mb;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ma <= ms_rst();
      mb <= ms_rst();
    end else begin
      ma <= step(ma, 1, 2, run_a, halt_a, final_pc_a);
      mb <= step(mb, 3, 1, run_b, halt_b, pp4_b);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act,
                      input logic exp);
    chk(nm, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic cmp_dut(input string p, input ms_t m,
                         input int lat, input int ec,
                         input logic [9:0] addr, input logic en,
                         input logic [31:0] ins, input logic iv,
                         input logic [31:0] pcv,
                         input logic [31:0] pp4, input logic cm,
                         input logic hl, input logic mis,
                         input logic [31:0] ret);
    logic busy;
    busy = (m.mode == 1);
    chk({p, "pc"}, pcv, m.pc);
    chk({p, "pc_plus4"}, pp4, m.pc + 32'd4);
    chk({p, "imem_addr"}, {22'b0, addr}, {22'b0, m.pc[11:2]});
    chkb({p, "imem_en"}, en, busy && m.k < lat);
    chkb({p, "instr_valid"}, iv, busy && m.k >= lat);
    chkb({p, "commit"}, cm, busy && m.k == lat + ec);
    chkb({p, "halted"}, hl, m.mode == 2);
    chkb({p, "misalign"}, mis, m.mis);
    chk({p, "retired"}, ret, m.ret);
    chk({p, "instr"}, ins, m.ins);
  endtask

  always @(negedge clk) begin
    cmp_dut("a_", ma, 1, 2, addr_a, en_a, instr_a, iv_a, pc_a,
            pp4_a, commit_a, halted_a, mis_a, ret_a);
    cmp_dut("b_", mb, 3, 1, addr_b, en_b, instr_b, iv_b, pc_b,
            pp4_b, commit_b, halted_b, mis_b, ret_b);
  end

  task automatic negs(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bound_ok(input string nm, input int n);
    checks++;
    if (n >= 40) begin
      errs++;
      $display("FAIL %s: waited %0d cycles, limit 40", nm, n);
    end
  endtask

  task automatic wait_commit_a(input string nm);
    int n;
    n = 0;
    while (commit_a !== 1'b1 && n < 40) begin negs(1); n++; end
    bound_ok(nm, n);
  endtask

  task automatic wait_exec_a(input string nm,
                             input logic [31:0] at);
    int n;
    n = 0;
    while (!(iv_a === 1'b1 && pc_a == at) && n < 40) begin
      negs(1); n++;
    end
    bound_ok(nm, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    run_a = 0; run_b = 0; halt_a = 0;
    fp_ovr = 0; fp_val = 32'h0;
    negs(2);
    chk("lit_rst_pc", pc_a, 32'h0);
    chk("lit_rst_ret", ret_a, 32'h0);
    chk("lit_rst_instr", instr_a, 32'h0);
    chkb("lit_rst_commit", commit_a, 1'b0);
    rst = 1; run_a = 1;
    negs(1);
    chkb("lit_c1_en", en_a, 1'b1);
    chk("lit_c1_addr", {22'b0, addr_a}, 32'h0);
    negs(1);
    chk("lit_c2_instr", instr_a, 32'hA5A5_0001);
    chkb("lit_c2_iv", iv_a, 1'b1);
    negs(1);
    chkb("lit_c3_iv", iv_a, 1'b1);
    negs(1);
    chkb("lit_c4_commit", commit_a, 1'b1);
    chk("lit_c4_pp4", pp4_a, 32'h4);
    negs(1);
    chk("lit_c5_pc", pc_a, 32'h4);

    // taken branch from pc=8
    wait_exec_a("wait_exec_8", 32'h8);
    fp_ovr = 1; fp_val = 32'h40;
    wait_commit_a("wait_commit_8");
    chk("lit_br_pp4", pp4_a, 32'hC);
    chk("lit_br_ret_before", ret_a, 32'h2);
    negs(1);
    chk("lit_br_addr", {22'b0, addr_a}, 32'd16);
    chk("lit_br_pc", pc_a, 32'h40);
    chk("lit_br_ret", ret_a, 32'h3);

    // misaligned target
    fp_val = 32'h46;
    wait_commit_a("wait_commit_40");
    negs(1);
    chk("lit_mis_pc", pc_a, 32'h44);
    chkb("lit_mis_flag", mis_a, 1'b1);
    fp_ovr = 0;
    wait_exec_a("wait_exec_48", 32'h48);
    fp_ovr = 1; fp_val = 32'h10;
    wait_commit_a("wait_commit_48");
    negs(1);
    fp_ovr = 0;
    chk("lit_jmp_pc", pc_a, 32'h10);
    chkb("lit_mis_sticky", mis_a, 1'b1);
    chk("lit_jmp_ret", ret_a, 32'h6);

    // halt in first EXEC cycle at pc=0x10
    negs(1);
    chkb("lit_halt_exec", iv_a, 1'b1);
    halt_a = 1;
    negs(1);
    halt_a = 0;
    chkb("lit_halted", halted_a, 1'b1);
    chk("lit_halt_pc", pc_a, 32'h10);
    chk("lit_halt_ret", ret_a, 32'h6);
    run_a = 0;
    negs(2);
    run_a = 1;
    negs(3);
    chkb("lit_halt_stays", halted_a, 1'b1);
    chkb("lit_halt_no_en", en_a, 1'b0);

    // latency-3 / exec-1 variant with run dropped mid-fetch
    rst = 0;
    negs(1);
    run_a = 0; rst = 1; run_b = 1;
    negs(1);
    chkb("lit_b_en1", en_b, 1'b1);
    negs(1);
    chkb("lit_b_en2", en_b, 1'b1);
    run_b = 0;
    negs(1);
    chkb("lit_b_en3", en_b, 1'b1);
    negs(1);
    chkb("lit_b_en_off", en_b, 1'b0);
    chk("lit_b_instr", instr_b, 32'hA5A5_0001);
    negs(1);
    chkb("lit_b_commit", commit_b, 1'b1);
    negs(1);
    chkb("lit_b_one_commit", commit_b, 1'b0);
    chk("lit_b_pc", pc_b, 32'h4);
    chk("lit_b_ret", ret_b, 32'h1);
    negs(3);
    chkb("lit_b_idle", en_b, 1'b0);

    // async reset in the middle of a commit cycle
    run_a = 1;
    negs(1);
    wait_exec_a("wait_exec_4", 32'h4);
    wait_commit_a("wait_commit_4");
    chk("lit_ar_pc_before", pc_a, 32'h4);
    #1 rst = 0;
    #1;
    chkb("lit_ar_commit", commit_a, 1'b0);
    chk("lit_ar_pc", pc_a, 32'h0);
    chk("lit_ar_ret", ret_a, 32'h0);
    chkb("lit_ar_iv", iv_a, 1'b0);
    chk("lit_ar_b_pc", pc_b, 32'h0);
    run_a = 0;
    negs(2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
